// File: rtl/rf_writeback_checker.sv
// Shadows register-file writebacks during a run, then walks a programmed table
// of (rd, expected) pairs against the shadow copy and reports pass/fail.
module rf_writeback_checker #(
  parameter int XLEN    = 64,
  parameter int NREG    = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_wr_en,
  input  logic [3:0]      cfg_idx,
  input  logic [4:0]      cfg_rd,
  input  logic [XLEN-1:0] cfg_data,
  input  logic [4:0]      cfg_count,
  input  logic            start,
  input  logic            halt,
  input  logic            clear,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [3:0]      err_idx,
  output logic [4:0]      err_rd,
  output logic [XLEN-1:0] err_actual,
  output logic [XLEN-1:0] err_expected,
  output logic [15:0]     cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_PASS, S_FAIL} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      tbl_rd_reg   [DEPTH];
  logic [XLEN-1:0] tbl_data_reg [DEPTH];
  logic [4:0]      count_reg;
  logic [3:0]      idx_reg;
  logic [15:0]     cycle_count_reg;
  logic [3:0]      err_idx_reg;
  logic [4:0]      err_rd_reg;
  logic [XLEN-1:0] err_actual_reg;
  logic [XLEN-1:0] err_expected_reg;
  logic [XLEN-1:0] shadow_val [NREG];

  logic            run_start;
  logic            run_exit;
  logic [4:0]      chk_rd;
  logic [XLEN-1:0] chk_expected;
  logic [XLEN-1:0] chk_actual;
  logic            chk_match;
  logic            chk_last;

  assign run_start = (state_reg == S_IDLE) && start;
  assign run_exit  = halt || (cycle_count_reg == 16'(TIMEOUT - 1));

  // x0 is a constant; every other register is cleared when a run starts.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_shadow
      if (gi == 0) begin : g_x0
        assign shadow_val[gi] = '0;
      end else begin : g_xn
        logic [XLEN-1:0] val_reg;
        always_ff @(posedge clk) begin
          if (rst || run_start) begin
            val_reg <= '0;
          end else if (state_reg == S_RUN && wb_en && wb_rd == 5'(gi)) begin
            val_reg <= wb_data;
          end
        end
        assign shadow_val[gi] = val_reg;
      end
    end
  endgenerate

  assign chk_rd       = tbl_rd_reg[idx_reg];
  assign chk_expected = tbl_data_reg[idx_reg];
  assign chk_actual   = shadow_val[chk_rd];
  assign chk_match    = (chk_actual == chk_expected);
  assign chk_last     = ({1'b0, idx_reg} == (count_reg - 5'd1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (run_exit) state_next = S_CHECK;
      S_CHECK: begin
        if (count_reg == 5'd0)  state_next = S_PASS;
        else if (!chk_match)    state_next = S_FAIL;
        else if (chk_last)      state_next = S_PASS;
      end
      S_PASS, S_FAIL: if (clear) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_rd_reg[i]   <= '0;
        tbl_data_reg[i] <= '0;
      end
      count_reg        <= '0;
      idx_reg          <= '0;
      cycle_count_reg  <= '0;
      err_idx_reg      <= '0;
      err_rd_reg       <= '0;
      err_actual_reg   <= '0;
      err_expected_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // The table write lands in the same edge as start, so the run sees it.
          if (cfg_wr_en && ({1'b0, cfg_idx} < 5'(DEPTH))) begin
            tbl_rd_reg[cfg_idx]   <= cfg_rd;
            tbl_data_reg[cfg_idx] <= cfg_data;
          end
          if (start) begin
            count_reg        <= (cfg_count > 5'(DEPTH)) ? 5'(DEPTH) : cfg_count;
            idx_reg          <= '0;
            cycle_count_reg  <= '0;
            err_idx_reg      <= '0;
            err_rd_reg       <= '0;
            err_actual_reg   <= '0;
            err_expected_reg <= '0;
          end
        end
        S_RUN: cycle_count_reg <= cycle_count_reg + 16'd1;
        S_CHECK: begin
          if (count_reg != 5'd0) begin
            if (!chk_match) begin
              err_idx_reg      <= idx_reg;
              err_rd_reg       <= chk_rd;
              err_actual_reg   <= chk_actual;
              err_expected_reg <= chk_expected;
            end else if (!chk_last) begin
              idx_reg <= idx_reg + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_reg == S_RUN) || (state_reg == S_CHECK);
  assign done         = (state_reg == S_PASS) || (state_reg == S_FAIL);
  assign pass         = (state_reg == S_PASS);
  assign fail         = (state_reg == S_FAIL);
  assign err_idx      = err_idx_reg;
  assign err_rd       = err_rd_reg;
  assign err_actual   = err_actual_reg;
  assign err_expected = err_expected_reg;
  assign cycle_count  = cycle_count_reg;

endmodule

// File: tb/tb_rf_writeback_checker.sv
// Scoreboard bench for rf_writeback_checker: a reference model predicts each
// run's verdict when the run is launched; the result is checked at done.
module tb_rf_writeback_checker;

  localparam int XLEN    = 64;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_wr_en;
  logic [3:0]      cfg_idx;
  logic [4:0]      cfg_rd;
  logic [XLEN-1:0] cfg_data;
  logic [4:0]      cfg_count;
  logic            start, halt, clear;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            busy, done, pass, fail;
  logic [3:0]      err_idx;
  logic [4:0]      err_rd;
  logic [XLEN-1:0] err_actual, err_expected;
  logic [15:0]     cycle_count;

  rf_writeback_checker #(.XLEN(XLEN), .NREG(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_rd(cfg_rd), .cfg_data(cfg_data),
    .cfg_count(cfg_count), .start(start), .halt(halt), .clear(clear),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .err_idx(err_idx), .err_rd(err_rd), .err_actual(err_actual),
    .err_expected(err_expected), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pass;
    logic [3:0]  idx;
    logic [4:0]  rd;
    logic [63:0] act;
    logic [63:0] exp;
    logic [15:0] cyc;
    logic [15:0] busy;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference table and per-cycle writeback schedule (index = RUN cycle, 1-based)
  logic [4:0]  m_rd   [DEPTH];
  logic [63:0] m_data [DEPTH];
  logic        sch_en   [256];
  logic [4:0]  sch_rd   [256];
  logic [63:0] sch_data [256];
  logic        sch_inj  [256];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 256; i++) begin
      sch_en[i] = 1'b0; sch_rd[i] = '0; sch_data[i] = '0; sch_inj[i] = 1'b0;
    end
  endtask

  task automatic sched_wb(input int c, input logic [4:0] rd, input logic [63:0] data);
    sch_en[c] = 1'b1; sch_rd[c] = rd; sch_data[c] = data;
  endtask

  task automatic cfg_write(input int idx, input logic [4:0] rd, input logic [63:0] data);
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_idx = idx[3:0]; cfg_rd = rd; cfg_data = data;
    if (idx < DEPTH) begin
      m_rd[idx] = rd; m_data[idx] = data;
    end
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic run_test(input string name, input logic [4:0] cnt, input int halt_at,
                          input bit sw_en, input int sw_idx, input logic [4:0] sw_rd,
                          input logic [63:0] sw_data);
    exp_t        e;
    exp_t        g;
    logic [63:0] m_sh [32];
    int          run_len, n, chk, busy_cnt, c;
    bit          got_done;
    if (sw_en) begin
      m_rd[sw_idx] = sw_rd; m_data[sw_idx] = sw_data;
    end
    run_len = (halt_at > 0 && halt_at < TIMEOUT) ? halt_at : TIMEOUT;
    for (int r = 0; r < 32; r++) m_sh[r] = '0;
    for (int k = 1; k <= run_len; k++)
      if (sch_en[k] && sch_rd[k] != 5'd0) m_sh[sch_rd[k]] = sch_data[k];
    n = (cnt > 5'(DEPTH)) ? DEPTH : int'(cnt);
    e = '0;
    e.pass = 1'b1;
    chk = (n == 0) ? 1 : n;
    for (int i = 0; i < n; i++) begin
      if (m_sh[m_rd[i]] != m_data[i]) begin
        e.pass = 1'b0; e.idx = i[3:0]; e.rd = m_rd[i];
        e.act = m_sh[m_rd[i]]; e.exp = m_data[i];
        chk = i + 1;
        break;
      end
    end
    e.cyc  = 16'(run_len);
    e.busy = 16'(run_len + chk);
    sb.push_back(e);

    @(negedge clk);
    start = 1'b1; cfg_count = cnt;
    if (sw_en) begin
      cfg_wr_en = 1'b1; cfg_idx = sw_idx[3:0]; cfg_rd = sw_rd; cfg_data = sw_data;
    end
    busy_cnt = 0; got_done = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      start = 1'b0; cfg_wr_en = 1'b0; wb_en = 1'b0; halt = 1'b0;
      if (done) begin got_done = 1'b1; break; end
      if (busy) busy_cnt++;
      if (busy_cnt >= 1 && busy_cnt < 256) begin
        c = busy_cnt;
        wb_en = sch_en[c]; wb_rd = sch_rd[c]; wb_data = sch_data[c];
        halt = (c == halt_at);
        if (sch_inj[c]) begin
          cfg_wr_en = 1'b1; cfg_idx = 4'd0; cfg_rd = 5'd3; cfg_data = 64'd77; start = 1'b1;
        end
      end
    end
    check_val({name, ".done_seen"}, 64'(got_done), 64'd1);
    g = sb.pop_front();
    if (got_done) begin
      check_val({name, ".pass"}, 64'(pass), 64'(g.pass));
      check_val({name, ".fail"}, 64'(fail), 64'(!g.pass));
      check_val({name, ".cycle_count"}, 64'(cycle_count), 64'(g.cyc));
      check_val({name, ".busy_cycles"}, 64'(busy_cnt), 64'(g.busy));
      if (!g.pass) begin
        check_val({name, ".err_idx"}, 64'(err_idx), 64'(g.idx));
        check_val({name, ".err_rd"}, 64'(err_rd), 64'(g.rd));
        check_val({name, ".err_actual"}, err_actual, g.act);
        check_val({name, ".err_expected"}, err_expected, g.exp);
      end
      $display("[TB] txn %s: pass=%0d fail=%0d cycle_count=%0d busy=%0d err_idx=%0d",
               name, pass, fail, cycle_count, busy_cnt, err_idx);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_val({name, ".cleared_done"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_idx = '0; cfg_rd = '0; cfg_data = '0;
    cfg_count = '0; start = 1'b0; halt = 1'b0; clear = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    for (int i = 0; i < DEPTH; i++) begin m_rd[i] = '0; m_data[i] = '0; end
    clear_sched();
    repeat (3) @(negedge clk);
    check_val("reset.busy", 64'(busy), 64'd0);
    check_val("reset.done", 64'(done), 64'd0);
    check_val("reset.pass", 64'(pass), 64'd0);
    check_val("reset.fail", 64'(fail), 64'd0);
    check_val("reset.cycle_count", 64'(cycle_count), 64'd0);
    check_val("reset.err_actual", err_actual, 64'd0);
    rst = 1'b0;

    // Zba program, runs to timeout
    sched_wb(1, 5'd1, 64'd5);  sched_wb(2, 5'd2, 64'd3);  sched_wb(3, 5'd3, 64'd11);
    sched_wb(4, 5'd4, 64'd17); sched_wb(5, 5'd5, 64'd29); sched_wb(6, 5'd6, 64'd8);
    cfg_write(0, 5'd1, 64'd5);  cfg_write(1, 5'd2, 64'd3);  cfg_write(2, 5'd3, 64'd11);
    cfg_write(3, 5'd4, 64'd17); cfg_write(4, 5'd5, 64'd29); cfg_write(5, 5'd6, 64'd8);
    cfg_write(6, 5'd7, 64'd0);
    run_test("zba_pass", 5'd7, 0, 1'b0, 0, 5'd0, 64'd0);

    cfg_write(3, 5'd4, 64'd18);
    run_test("zba_corrupt", 5'd7, 0, 1'b0, 0, 5'd0, 64'd0);

    // x0 writes discarded, overwrite of x5, halt on last write
    clear_sched();
    sched_wb(1, 5'd0, 64'd99); sched_wb(2, 5'd5, 64'd1); sched_wb(3, 5'd5, 64'd29);
    cfg_write(0, 5'd0, 64'd0); cfg_write(1, 5'd5, 64'd29);
    run_test("x0_overwrite", 5'd2, 3, 1'b0, 0, 5'd0, 64'd0);

    clear_sched();
    run_test("count0_halt4", 5'd0, 4, 1'b0, 0, 5'd0, 64'd0);

    // cfg write and start during RUN are ignored
    clear_sched();
    sched_wb(1, 5'd3, 64'd11);
    sch_inj[2] = 1'b1;
    cfg_write(0, 5'd3, 64'd11);
    run_test("ignore_in_run", 5'd1, 4, 1'b0, 0, 5'd0, 64'd0);

    // Second run: shadow must be cleared, so x3 reads 0
    clear_sched();
    cfg_write(0, 5'd3, 64'd0);
    run_test("shadow_cleared", 5'd1, 2, 1'b0, 0, 5'd0, 64'd0);

    // Count saturation plus a table write coinciding with start
    clear_sched();
    for (int i = 0; i < DEPTH; i++) begin
      sched_wb(i + 1, 5'(i + 1), 64'(3 * i + 1));
      cfg_write(i, 5'(i + 1), 64'(3 * i + 1));
    end
    run_test("saturate_samecycle", 5'd20, 16, 1'b1, 15, 5'd16, 64'd999);

    // Reset in the second CHECK cycle
    clear_sched();
    cfg_write(0, 5'd0, 64'd0); cfg_write(1, 5'd0, 64'd0); cfg_write(2, 5'd0, 64'd0);
    begin
      int bc;
      bit hit;
      bc = 0; hit = 1'b0;
      @(negedge clk);
      start = 1'b1; cfg_count = 5'd3;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        start = 1'b0; halt = 1'b0;
        if (busy) bc++;
        if (bc == 2) halt = 1'b1;
        if (bc == 4) begin rst = 1'b1; hit = 1'b1; break; end
      end
      check_val("rst_mid.reached_check", 64'(hit), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin m_rd[i] = '0; m_data[i] = '0; end
      check_val("rst_mid.busy", 64'(busy), 64'd0);
      check_val("rst_mid.done", 64'(done), 64'd0);
      check_val("rst_mid.pass", 64'(pass), 64'd0);
      check_val("rst_mid.fail", 64'(fail), 64'd0);
      check_val("rst_mid.cycle_count", 64'(cycle_count), 64'd0);
      check_val("rst_mid.err_rd", 64'(err_rd), 64'd0);
      $display("[TB] txn rst_mid_check: busy=%0d done=%0d cycle_count=%0d", busy, done, cycle_count);
    end

    // After reset the table is all {x0:0}, so a full-depth check passes
    clear_sched();
    sched_wb(1, 5'd9, 64'd123);
    run_test("table_after_reset", 5'd16, 1, 1'b0, 0, 5'd0, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
